// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// restart counter width and counter sizing functions.
package rst_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  localparam int RESTART_CNT_W = 8;

  // Bits needed to hold any value from 0 up to maxCount inclusive.
  function automatic int cntWidth(input int maxCount);
    return $clog2(maxCount + 1);
  endfunction

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchroniser for an asynchronous input, followed by a counter
// debouncer that only accepts a new level after DEB_CYCLES stable samples.
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout_sync,
  output logic dout_deb
);
  import rst_sequencer_pkg::*;

  localparam int               DEB_W    = cntWidth(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DEB_W-1:0]       r_debCnt;
  logic                   r_debVal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Any sample equal to the current debounced level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_debCnt <= '0;
      r_debVal <= 1'b0;
    end else if (r_sync[SYNC_STAGES-1] == r_debVal) begin
      r_debCnt <= '0;
    end else if (r_debCnt == DEB_LAST) begin
      r_debCnt <= '0;
      r_debVal <= ~r_debVal;
    end else begin
      r_debCnt <= r_debCnt + DEB_W'(1);
    end
  end

  assign dout_sync = r_sync[SYNC_STAGES-1];
  assign dout_deb  = r_debVal;

endmodule

// File: rtl/rst_sequencer.sv
// Power-on / reset sequencer: holds downstream domains in reset until PLL lock
// is stable and the button is released, then releases channels one by one.
module rst_sequencer #(
  parameter int N_OUT       = 4,
  parameter int STRETCH     = 16,
  parameter int STAGGER     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 65000
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        locked,
  input  logic                                        btn,
  output logic [N_OUT-1:0]                            rst_out,
  output logic                                        ready,
  output logic [rst_sequencer_pkg::RESTART_CNT_W-1:0] restart_cnt
);
  import rst_sequencer_pkg::*;

  localparam int CNT_W = cntWidth(maxOf3(STRETCH, STAGGER, DEB_CYCLES));
  localparam int IDX_W = cntWidth(N_OUT);

  localparam logic [CNT_W-1:0]         STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0]         STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]         IDX_LAST     = IDX_W'(N_OUT - 1);
  localparam logic [RESTART_CNT_W-1:0] RC_MAX       = '1;

  logic w_lockedSync;
  logic w_btnDeb;
  logic w_unusedLockedDeb;
  logic w_unusedBtnSync;
  logic w_bad;

  seq_state_t               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [N_OUT-1:0]         r_rstOut;
  logic                     r_ready;
  logic [RESTART_CNT_W-1:0] r_restartCnt;

  seq_state_t               w_stateNext;
  logic [CNT_W-1:0]         w_cntNext;
  logic [IDX_W-1:0]         w_idxNext;
  logic [N_OUT-1:0]         w_rstOutNext;
  logic                     w_readyNext;
  logic [RESTART_CNT_W-1:0] w_restartCntNext;

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_lockedSync (
    .clk      (clk),
    .rst      (rst),
    .din      (locked),
    .dout_sync(w_lockedSync),
    .dout_deb (w_unusedLockedDeb)
  );

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btnDebounce (
    .clk      (clk),
    .rst      (rst),
    .din      (btn),
    .dout_sync(w_unusedBtnSync),
    .dout_deb (w_btnDeb)
  );

  assign w_bad = !w_lockedSync || w_btnDeb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= HOLD;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_rstOut     <= '1;
      r_ready      <= 1'b0;
      r_restartCnt <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_cnt        <= w_cntNext;
      r_idx        <= w_idxNext;
      r_rstOut     <= w_rstOutNext;
      r_ready      <= w_readyNext;
      r_restartCnt <= w_restartCntNext;
    end
  end

  // Each channel bit lives in its own flop, so releases never glitch.
  always_comb begin
    w_stateNext      = r_state;
    w_cntNext        = r_cnt;
    w_idxNext        = r_idx;
    w_rstOutNext     = r_rstOut;
    w_restartCntNext = r_restartCnt;

    case (r_state)
      HOLD: begin
        w_rstOutNext = '1;
        w_cntNext    = '0;
        w_idxNext    = '0;
        if (!w_bad) begin
          w_stateNext = rst_sequencer_pkg::STRETCH;
        end
      end

      rst_sequencer_pkg::STRETCH: begin
        if (w_bad) begin
          w_stateNext = HOLD;
        end else if (r_cnt == STRETCH_LAST) begin
          w_stateNext     = RELEASE;
          w_cntNext       = '0;
          w_idxNext       = '0;
          w_rstOutNext[0] = 1'b0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (w_bad) begin
          w_stateNext = HOLD;
        end else if (r_idx == IDX_LAST) begin
          w_stateNext = RUN;
        end else if (r_cnt == STAGGER_LAST) begin
          w_cntNext = '0;
          w_idxNext = r_idx + IDX_W'(1);
          for (int i = 0; i < N_OUT; i++) begin
            if (IDX_W'(i) == w_idxNext) w_rstOutNext[i] = 1'b0;
          end
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end

      RUN: begin
        if (w_bad) begin
          w_stateNext = HOLD;
        end
      end

      default: begin
        w_stateNext = HOLD;
      end
    endcase

    // Leaving an active state for HOLD is a restart; staying in HOLD is not.
    if (r_state != HOLD && w_stateNext == HOLD) begin
      w_rstOutNext = '1;
      w_cntNext    = '0;
      w_idxNext    = '0;
      if (r_restartCnt != RC_MAX) begin
        w_restartCntNext = r_restartCnt + RESTART_CNT_W'(1);
      end
    end

    w_readyNext = (w_stateNext == RUN);
  end

  assign rst_out     = r_rstOut;
  assign ready       = r_ready;
  assign restart_cnt = r_restartCnt;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: three instances (default, single channel, unit stagger)
// share inputs; expected outputs are queued per cycle and compared on negedges.
module tb_rst_sequencer;

  typedef struct {
    int         cyc;
    int         dut;
    logic [3:0] rstOut;
    logic       ready;
    logic [7:0] rc;
  } sbEntry_t;

  logic clk;
  logic rst;
  logic locked;
  logic btn;

  logic [3:0] rstOutA;
  logic [0:0] rstOutB;
  logic [3:0] rstOutC;
  logic       readyA, readyB, readyC;
  logic [7:0] rcA, rcB, rcC;

  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;
  int       c;
  sbEntry_t sb[$];

  rst_sequencer #(.N_OUT(4), .STRETCH(16), .STAGGER(8), .SYNC_STAGES(2), .DEB_CYCLES(4)) dutA (
    .clk(clk), .rst(rst), .locked(locked), .btn(btn),
    .rst_out(rstOutA), .ready(readyA), .restart_cnt(rcA)
  );

  rst_sequencer #(.N_OUT(1), .STRETCH(16), .STAGGER(8), .SYNC_STAGES(2), .DEB_CYCLES(4)) dutB (
    .clk(clk), .rst(rst), .locked(locked), .btn(btn),
    .rst_out(rstOutB), .ready(readyB), .restart_cnt(rcB)
  );

  rst_sequencer #(.N_OUT(4), .STRETCH(16), .STAGGER(1), .SYNC_STAGES(2), .DEB_CYCLES(4)) dutC (
    .clk(clk), .rst(rst), .locked(locked), .btn(btn),
    .rst_out(rstOutC), .ready(readyC), .restart_cnt(rcC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] obsRst(int d);
    case (d)
      0:       return rstOutA;
      1:       return {3'b000, rstOutB};
      default: return rstOutC;
    endcase
  endfunction

  function automatic logic obsReady(int d);
    case (d)
      0:       return readyA;
      1:       return readyB;
      default: return readyC;
    endcase
  endfunction

  function automatic logic [7:0] obsRc(int d);
    case (d)
      0:       return rcA;
      1:       return rcB;
      default: return rcC;
    endcase
  endfunction

  task automatic doCheck(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkDut(string tag, int d, logic [3:0] r, logic rdy, logic [7:0] rc);
    doCheck($sformatf("%s_dut%0d_rst_out", tag, d), {28'd0, obsRst(d)}, {28'd0, r});
    doCheck($sformatf("%s_dut%0d_ready", tag, d), {31'd0, obsReady(d)}, {31'd0, rdy});
    doCheck($sformatf("%s_dut%0d_restart_cnt", tag, d), {24'd0, obsRc(d)}, {24'd0, rc});
  endtask

  // Checks all three instances right now for either all-held or all-released outputs.
  task automatic checkAll(string tag, bit allOnes, logic rdy, logic [7:0] rc);
    checkDut(tag, 0, allOnes ? 4'b1111 : 4'b0000, rdy, rc);
    checkDut(tag, 1, allOnes ? 4'b0001 : 4'b0000, rdy, rc);
    checkDut(tag, 2, allOnes ? 4'b1111 : 4'b0000, rdy, rc);
  endtask

  task automatic expectAt(int at, int d, logic [3:0] r, logic rdy, logic [7:0] rc);
    sbEntry_t e;
    e.cyc    = at;
    e.dut    = d;
    e.rstOut = r;
    e.ready  = rdy;
    e.rc     = rc;
    sb.push_back(e);
  endtask

  task automatic expectAll(int at, bit allOnes, logic rdy, logic [7:0] rc);
    expectAt(at, 0, allOnes ? 4'b1111 : 4'b0000, rdy, rc);
    expectAt(at, 1, allOnes ? 4'b0001 : 4'b0000, rdy, rc);
    expectAt(at, 2, allOnes ? 4'b1111 : 4'b0000, rdy, rc);
  endtask

  task automatic pushLim(int at, int limit, int d, logic [3:0] r, logic rdy, logic [7:0] rc);
    if (at < limit) expectAt(at, d, r, rdy, rc);
  endtask

  // Release schedule when locked_s (or !btn_db) first goes good two edges after cycle c0.
  task automatic pushBasic(int c0, logic [7:0] rc, int limit);
    pushLim(c0 + 18, limit, 0, 4'b1111, 1'b0, rc);
    pushLim(c0 + 19, limit, 0, 4'b1110, 1'b0, rc);
    pushLim(c0 + 26, limit, 0, 4'b1110, 1'b0, rc);
    pushLim(c0 + 27, limit, 0, 4'b1100, 1'b0, rc);
    pushLim(c0 + 34, limit, 0, 4'b1100, 1'b0, rc);
    pushLim(c0 + 35, limit, 0, 4'b1000, 1'b0, rc);
    pushLim(c0 + 42, limit, 0, 4'b1000, 1'b0, rc);
    pushLim(c0 + 43, limit, 0, 4'b0000, 1'b0, rc);
    pushLim(c0 + 44, limit, 0, 4'b0000, 1'b1, rc);
    pushLim(c0 + 18, limit, 1, 4'b0001, 1'b0, rc);
    pushLim(c0 + 19, limit, 1, 4'b0000, 1'b0, rc);
    pushLim(c0 + 20, limit, 1, 4'b0000, 1'b1, rc);
    pushLim(c0 + 18, limit, 2, 4'b1111, 1'b0, rc);
    pushLim(c0 + 19, limit, 2, 4'b1110, 1'b0, rc);
    pushLim(c0 + 20, limit, 2, 4'b1100, 1'b0, rc);
    pushLim(c0 + 21, limit, 2, 4'b1000, 1'b0, rc);
    pushLim(c0 + 22, limit, 2, 4'b0000, 1'b0, rc);
    pushLim(c0 + 23, limit, 2, 4'b0000, 1'b1, rc);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic stepTo(int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Scoreboard drain: entries due this cycle are compared, overdue ones are flagged.
  always @(negedge clk) begin
    sbEntry_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        checkDut($sformatf("cyc%0d", sb[i].cyc), sb[i].dut, sb[i].rstOut, sb[i].ready, sb[i].rc);
      end else if (sb[i].cyc < cyc) begin
        doCheck($sformatf("overdue_dut%0d", sb[i].dut), sb[i].cyc, cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    btn    = 1'b0;
    step(3);
    checkAll("reset", 1'b1, 1'b0, 8'd0);
    rst = 1'b0;
    step(2);
    checkAll("hold_unlocked", 1'b1, 1'b0, 8'd0);

    $display("[TB] basic sequence");
    c = cyc;
    locked = 1'b1;
    pushBasic(c, 8'd0, 32'h7fffffff);
    stepTo(c + 50);
    checkAll("basic_run", 1'b0, 1'b1, 8'd0);

    $display("[TB] async reset pulse in RUN, then lock loss mid-release");
    c = cyc;
    #2 rst = 1'b1;
    #1 checkAll("async_rst", 1'b1, 1'b0, 8'd0);
    #1 rst = 1'b0;
    pushBasic(c, 8'd0, c + 30);
    expectAt(c + 30, 0, 4'b1100, 1'b0, 8'd0);
    expectAt(c + 30, 1, 4'b0000, 1'b1, 8'd0);
    expectAt(c + 30, 2, 4'b0000, 1'b1, 8'd0);
    expectAll(c + 31, 1'b1, 1'b0, 8'd1);
    stepTo(c + 28);
    locked = 1'b0;
    stepTo(c + 33);
    c = cyc;
    locked = 1'b1;
    pushBasic(c, 8'd1, 32'h7fffffff);
    stepTo(c + 50);

    $display("[TB] debounce");
    c = cyc;
    btn = 1'b1;
    step(3);
    btn = 1'b0;
    expectAll(c + 10, 1'b0, 1'b1, 8'd1);
    stepTo(c + 12);
    c = cyc;
    btn = 1'b1;
    expectAll(c + 6, 1'b0, 1'b1, 8'd1);
    expectAll(c + 7, 1'b1, 1'b0, 8'd2);
    expectAll(c + 12, 1'b1, 1'b0, 8'd2);
    stepTo(c + 12);
    c = cyc;
    btn = 1'b0;
    pushBasic(c + 4, 8'd2, 32'h7fffffff);
    stepTo(c + 60);

    $display("[TB] restart counter saturation");
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      step(4);
      locked = 1'b1;
      step(4);
    end
    checkAll("saturate", 1'b1, 1'b0, 8'd255);

    step(2);
    doCheck("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
